// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator.
// Build option: TEST_PATTERN_EN adds the colour-bar rgb output.
package video_timing_pkg;

    localparam int CNT_W     = 11;
    localparam int MAX_TOTAL = 2048;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam bit ACTIVE_LOW  = 1'b0;
    localparam bit ACTIVE_HIGH = 1'b1;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

endpackage

// File: rtl/video_timing_if.sv
// Raster timing bundle from the timing generator to the DVI encoder.
// Build option: TEST_PATTERN_EN adds the rgb signal.
interface video_timing_if;
    import video_timing_pkg::*;

    logic             hsync;
    logic             vsync;
    logic             de;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;
`ifdef TEST_PATTERN_EN
    logic [23:0]      rgb;
`endif

    modport master (
        output hsync, vsync, de, x, y, line_start, frame_start
`ifdef TEST_PATTERN_EN
        , output rgb
`endif
    );

    modport slave (
        input hsync, vsync, de, x, y, line_start, frame_start
`ifdef TEST_PATTERN_EN
        , input rgb
`endif
    );

endinterface

// File: rtl/video_timing_gen_color_bar.sv
// Eight vertical colour bars selected from the pixel column.
// Used only when TEST_PATTERN_EN is defined; output is combinational.
module color_bar_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic [CNT_W-1:0] x,
    output logic [23:0]      rgb
);

    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [CNT_W-1:0] bar;

    assign bar = x / CNT_W'(BAR_W);

    // Map bar index to its colour; anything past the last bar is black
    always_comb begin
        rgb = COL_BLACK;
        if (bar[CNT_W-1:3] == '0) begin
            unique case (bar[2:0])
                3'd0: rgb = COL_WHITE;
                3'd1: rgb = COL_YELLOW;
                3'd2: rgb = COL_CYAN;
                3'd3: rgb = COL_GREEN;
                3'd4: rgb = COL_MAGENTA;
                3'd5: rgb = COL_RED;
                3'd6: rgb = COL_BLUE;
                3'd7: rgb = COL_BLACK;
            endcase
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters with registered sync, de and coords.
// Build option: TEST_PATTERN_EN adds registered colour bars on vid.rgb.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = ACTIVE_LOW,
    parameter bit VS_POL   = ACTIVE_LOW
) (
    input  logic           pixclk,
    input  logic           reset,
    input  logic           enable,
    video_timing_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
        $error("video_timing_gen: total exceeds 11-bit counter range");
    end

    // One extra bit so sync end points never wrap at a 2048 total
    typedef logic [CNT_W:0] cmp_t;

    localparam cmp_t HA  = cmp_t'(H_ACTIVE);
    localparam cmp_t HS0 = cmp_t'(H_ACTIVE + H_FP);
    localparam cmp_t HS1 = cmp_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cmp_t VA  = cmp_t'(V_ACTIVE);
    localparam cmp_t VS0 = cmp_t'(V_ACTIVE + V_FP);
    localparam cmp_t VS1 = cmp_t'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    cmp_t             hc;
    cmp_t             vc;
    logic             vis;
    logic             hs_act;
    logic             vs_act;
    logic             ls_n;
    logic             fs_n;
    logic [CNT_W-1:0] x_n;
    logic [CNT_W-1:0] y_n;

    assign hc = {1'b0, h_cnt};
    assign vc = {1'b0, v_cnt};

    // Decode the current counter position into next output values
    always_comb begin
        vis    = (hc < HA) && (vc < VA);
        hs_act = (hc >= HS0) && (hc < HS1);
        vs_act = (vc >= VS0) && (vc < VS1);
        ls_n   = (h_cnt == '0) && (vc < VA);
        fs_n   = (h_cnt == '0) && (v_cnt == '0);
        x_n    = vis ? h_cnt : '0;
        y_n    = vis ? v_cnt : '0;
    end

    // Raster counters: h wraps each line, v steps on each h wrap
    always_ff @(posedge pixclk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (enable) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

`ifdef TEST_PATTERN_EN
    logic [23:0] bar_rgb;

    color_bar_gen #(
        .H_ACTIVE(H_ACTIVE)
    ) u_bars (
        .x  (x_n),
        .rgb(bar_rgb)
    );

    // Colour registered alongside de so it stays pixel-aligned
    always_ff @(posedge pixclk) begin
        if (reset) begin
            vid.rgb <= '0;
        end else if (enable && vis) begin
            vid.rgb <= bar_rgb;
        end else begin
            vid.rgb <= '0;
        end
    end
`endif

    // Register outputs; while paused, syncs and coords hold, pulses drop
    always_ff @(posedge pixclk) begin
        if (reset) begin
            vid.hsync       <= ~HS_POL;
            vid.vsync       <= ~VS_POL;
            vid.de          <= 1'b0;
            vid.x           <= '0;
            vid.y           <= '0;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end else if (enable) begin
            vid.hsync       <= hs_act ? HS_POL : ~HS_POL;
            vid.vsync       <= vs_act ? VS_POL : ~VS_POL;
            vid.de          <= vis;
            vid.x           <= x_n;
            vid.y           <= y_n;
            vid.line_start  <= ls_n;
            vid.frame_start <= fs_n;
        end else begin
            vid.de          <= 1'b0;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a reduced 24x12 raster.
// Build option: TEST_PATTERN_EN also checks the colour bars.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    video_timing_if vif();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(ACTIVE_LOW), .VS_POL(ACTIVE_LOW)
    ) dut (
        .pixclk(clk),
        .reset (rst),
        .enable(en),
        .vid   (vif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          mh = 0, mv = 0;
    logic        e_de, e_hs, e_vs, e_ls, e_fs;
    int          e_x, e_y;
    logic [23:0] e_rgb;

    typedef struct {
        logic r, e;
        logic de, hs, vs, ls, fs;
        int   x, y;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [23:0] bar_col(input int b);
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic model(input logic r, input logic e);
        logic vis;
        if (r) begin
            mh = 0; mv = 0;
            e_de = 0; e_hs = 1; e_vs = 1; e_ls = 0; e_fs = 0;
            e_x = 0; e_y = 0; e_rgb = 0;
        end else if (e) begin
            vis   = (mh < HA) && (mv < VA);
            e_de  = vis;
            e_x   = vis ? mh : 0;
            e_y   = vis ? mv : 0;
            e_hs  = !(mh >= HA + HF && mh < HA + HF + HS);
            e_vs  = !(mv >= VA + VF && mv < VA + VF + VS);
            e_ls  = (mh == 0) && (mv < VA);
            e_fs  = (mh == 0) && (mv == 0);
            e_rgb = vis ? bar_col(mh / (HA / 8)) : 24'h0;
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) mv = 0;
            end
        end else begin
            e_de = 0; e_ls = 0; e_fs = 0; e_rgb = 0;
        end
    endtask

    task automatic cyc(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        #2;
        model(r, e);
    endtask

    task automatic chk(input string nm, input logic de, hs, vs, ls, fs,
                       input int x, y);
        checks++;
        if (vif.de !== de || vif.hsync !== hs || vif.vsync !== vs ||
            vif.line_start !== ls || vif.frame_start !== fs ||
            vif.x !== 11'(x) || vif.y !== 11'(y)) begin
            errors++;
            $display("FAIL %s: got de%b hs%b vs%b ls%b fs%b x%0d y%0d, want de%b hs%b vs%b ls%b fs%b x%0d y%0d",
                     nm, vif.de, vif.hsync, vif.vsync, vif.line_start,
                     vif.frame_start, vif.x, vif.y, de, hs, vs, ls, fs, x, y);
        end
    endtask

    task automatic chkv(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic chk_rgb(input string nm, input logic [23:0] want);
`ifdef TEST_PATTERN_EN
        checks++;
        if (vif.rgb !== want) begin
            errors++;
            $display("FAIL %s: got rgb %h, want %h", nm, vif.rgb, want);
        end
`else
        if (want === 24'hx) $display("unused");
`endif
    endtask

    task automatic chk_model(input string nm);
        chk(nm, e_de, e_hs, e_vs, e_ls, e_fs, e_x, e_y);
`ifdef TEST_PATTERN_EN
        chk_rgb({nm, "_rgb"}, e_rgb);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_fs, t_der, t_hf, t_vf, de_cnt, ls_cnt;
        logic p_de, p_hs, p_vs;
        bit found;

        tbl[0] = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
        tbl[2] = '{0, 1, 1, 1, 1, 0, 0, 1, 0};
        tbl[3] = '{0, 0, 0, 1, 1, 0, 0, 1, 0};
        tbl[4] = '{0, 0, 0, 1, 1, 0, 0, 1, 0};
        tbl[5] = '{0, 1, 1, 1, 1, 0, 0, 2, 0};
        tbl[6] = '{1, 0, 0, 1, 1, 0, 0, 0, 0};
        tbl[7] = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
        tbl[8] = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
        tbl[9] = '{0, 1, 1, 1, 1, 0, 0, 1, 0};

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].r, tbl[i].e);
            chk($sformatf("vec%0d", i), tbl[i].de, tbl[i].hs, tbl[i].vs,
                tbl[i].ls, tbl[i].fs, tbl[i].x, tbl[i].y);
        end

        // Two full frames from reset with per-cycle and interval checks
        cyc(1, 1);
        chk_model("frame_reset");
        t_fs = -1; t_der = -1; t_hf = -1; t_vf = -1;
        de_cnt = 0; ls_cnt = 0;
        p_de = 0; p_hs = 1; p_vs = 1;
        for (int k = 1; k <= 2 * FT + 2; k++) begin
            cyc(0, 1);
            chk_model("frame_run");
            if (vif.frame_start === 1'b1) begin
                if (t_fs >= 0) begin
                    chkv("fs_spacing", k - t_fs, FT);
                    chkv("de_per_frame", de_cnt, HA * VA);
                    chkv("ls_per_frame", ls_cnt, VA);
                end
                t_fs = k; de_cnt = 0; ls_cnt = 0;
            end
            if (vif.de === 1'b1) de_cnt++;
            if (vif.line_start === 1'b1) ls_cnt++;
            if (vif.de === 1'b1 && p_de !== 1'b1) t_der = k;
            if (vif.hsync === 1'b0 && p_hs === 1'b1) begin
                if (t_der >= 0) chkv("hs_offset", (k - t_der) % HT, HA + HF);
                t_hf = k;
            end
            if (vif.hsync === 1'b1 && p_hs === 1'b0 && t_hf >= 0)
                chkv("hs_width", k - t_hf, HS);
            if (vif.vsync === 1'b0 && p_vs === 1'b1) begin
                if (t_fs >= 0) chkv("vs_offset", k - t_fs, (VA + VF) * HT);
                t_vf = k;
            end
            if (vif.vsync === 1'b1 && p_vs === 1'b0 && t_vf >= 0)
                chkv("vs_width", k - t_vf, VS * HT);
            p_de = vif.de; p_hs = vif.hsync; p_vs = vif.vsync;
        end

        // Pause enable for 10 cycles while x=10 on line 3
        found = 0;
        for (int n = 0; n < 2 * FT && !found; n++) begin
            cyc(0, 1);
            if (vif.de === 1'b1 && vif.x == 11'd10 && vif.y == 11'd3)
                found = 1;
        end
        chkv("wait_x10", int'(found), 1);
        for (int n = 0; n < 10; n++) begin
            cyc(0, 0);
            chk("gap_hold", 0, 1, 1, 0, 0, 10, 3);
        end
        cyc(0, 1);
        chk("resume_x11", 1, 1, 1, 0, 0, 11, 3);
        cyc(0, 1);
        chk("resume_x12", 1, 1, 1, 0, 0, 12, 3);

        // Reset mid-frame at (7,5), then restart from (0,0)
        found = 0;
        for (int n = 0; n < 2 * FT && !found; n++) begin
            cyc(0, 1);
            if (vif.de === 1'b1 && vif.x == 11'd7 && vif.y == 11'd5)
                found = 1;
        end
        chkv("wait_x7y5", int'(found), 1);
        cyc(1, 1);
        chk("mid_reset", 0, 1, 1, 0, 0, 0, 0);
        chk_rgb("mid_reset_rgb", 24'h000000);
        cyc(0, 1);
        chk("post_reset", 1, 1, 1, 1, 1, 0, 0);
        chk_rgb("rgb_x0", 24'hFFFFFF);

        // Walk the rest of line 0 through the bars and into blanking
        for (int i = 1; i < HT; i++) begin
            cyc(0, 1);
            chk_model("line0");
            if (i == 2)  chk_rgb("rgb_x2", 24'hFFFF00);
            if (i == 15) chk_rgb("rgb_x15", 24'h000000);
            if (i == 16) begin
                chk("blank_de", 0, 1, 1, 0, 0, 0, 0);
                chk_rgb("rgb_blank", 24'h000000);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
